// File: rtl/puf_response_sequencer.sv
// Sequences a ring-oscillator PUF: for each RO pair it clears the counters,
// lets the oscillators settle, counts for a fixed window and captures one response bit.
module puf_response_sequencer #(
  parameter int NUM_BITS      = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_CYCLES = 256,
  parameter int CNT_W         = 8,
  localparam int IDX_W        = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [IDX_W-1:0]    pair_sel,
  output logic                ro_enable,
  output logic                cnt_clear,
  output logic                cnt_en,
  input  logic [CNT_W-1:0]    count_a,
  input  logic [CNT_W-1:0]    count_b,
  output logic                busy,
  output logic                resp_valid,
  output logic [NUM_BITS-1:0] response,
  output logic [NUM_BITS-1:0] tie_mask,
  output logic [2:0]          state_dbg
);

  localparam int MAX_C = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SETTLE  = 3'd2,
    S_COUNT   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] resp_q, resp_d;
  logic [NUM_BITS-1:0] tie_q, tie_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
    end
  end

  // The cycle counter is loaded with length-1 on entry and the phase ends when it reads zero.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          resp_d  = '0;
          tie_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_SETTLE;
        cnt_d   = CW'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_COUNT;
          cnt_d   = CW'(WINDOW_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_COUNT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CAPTURE: begin
        resp_d[idx_q] = (count_a > count_b);
        tie_d[idx_q]  = (count_a == count_b);
        if (idx_q == IDX_W'(NUM_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition and freezes whatever was already captured.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
    end
  end

  assign pair_sel   = idx_q;
  assign cnt_clear  = (state_q == S_CLEAR);
  assign ro_enable  = (state_q == S_SETTLE) || (state_q == S_COUNT);
  assign cnt_en     = (state_q == S_COUNT);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign response   = resp_q;
  assign tie_mask   = tie_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Bench for puf_response_sequencer: cycle-accurate expectations derived from the
// per-bit phase schedule, with per-pair counts driven from randomized tables.
module tb_puf_response_sequencer;
  localparam int NB     = 4;
  localparam int SC     = 2;
  localparam int WC     = 8;
  localparam int CW     = 8;
  localparam int P      = SC + WC + 2;
  localparam int LAST_C = NB * P + 1;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [1:0]    pair_sel;
  logic          ro_enable, cnt_clear, cnt_en, busy, resp_valid;
  logic [CW-1:0] count_a, count_b;
  logic [NB-1:0] response, tie_mask;
  logic [2:0]    state_dbg;

  int tests = 0;
  int fails = 0;
  logic [CW-1:0] ca [NB];
  logic [CW-1:0] cb [NB];

  puf_response_sequencer #(
    .NUM_BITS(NB), .SETTLE_CYCLES(SC), .WINDOW_CYCLES(WC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pair_sel(pair_sel), .ro_enable(ro_enable), .cnt_clear(cnt_clear), .cnt_en(cnt_en),
    .count_a(count_a), .count_b(count_b), .busy(busy), .resp_valid(resp_valid),
    .response(response), .tie_mask(tie_mask), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] exp_bits(input int n, input bit want_tie);
    logic [NB-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++)
      r[j] = want_tie ? (ca[j] == cb[j]) : (ca[j] > cb[j]);
    return r;
  endfunction

  function automatic int pair_of(input int c);
    return (c <= NB * P) ? (c - 1) / P : NB - 1;
  endfunction

  function automatic int ncap_of(input int c);
    int n;
    n = (c - 1) / P;
    return (n > NB) ? NB : n;
  endfunction

  task automatic randomize_counts();
    for (int j = 0; j < NB; j++) begin
      ca[j] = CW'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cb[j] = ca[j];
      else                           cb[j] = CW'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_counts(input int c);
    count_a = ca[pair_of(c)];
    count_b = cb[pair_of(c)];
  endtask

  // Cycle c is the interval ending at the c-th edge after the one that sampled start.
  task automatic check_cycle(input int c);
    int o;
    bit clr, ro, en, rv, bsy;
    clr = 0; ro = 0; en = 0; rv = 0; bsy = 0;
    if (c <= NB * P) begin
      o   = (c - 1) % P;
      clr = (o == 0);
      ro  = (o >= 1) && (o <= SC + WC);
      en  = (o > SC) && (o <= SC + WC);
      bsy = 1;
    end else if (c == LAST_C) begin
      rv  = 1;
      bsy = 1;
    end
    check($sformatf("c%0d cnt_clear", c), cnt_clear, clr);
    check($sformatf("c%0d ro_enable", c), ro_enable, ro);
    check($sformatf("c%0d cnt_en", c), cnt_en, en);
    check($sformatf("c%0d busy", c), busy, bsy);
    check($sformatf("c%0d resp_valid", c), resp_valid, rv);
    check($sformatf("c%0d pair_sel", c), pair_sel, pair_of(c));
    check($sformatf("c%0d response", c), response, exp_bits(ncap_of(c), 0));
    check($sformatf("c%0d tie_mask", c), tie_mask, exp_bits(ncap_of(c), 1));
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, " pair_sel"}, pair_sel, 0);
    check({tag, " ro_enable"}, ro_enable, 0);
    check({tag, " cnt_clear"}, cnt_clear, 0);
    check({tag, " cnt_en"}, cnt_en, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " resp_valid"}, resp_valid, 0);
    check({tag, " response"}, response, 0);
    check({tag, " tie_mask"}, tie_mask, 0);
  endtask

  // A negative cycle number disables the corresponding event.
  task automatic run(input int abort_c, input int rst_c, input int p1, input int p2);
    logic [NB-1:0] r_exp, t_exp;
    int pidx;
    drive_counts(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= LAST_C + 3; c++) begin
      drive_counts(c);
      check_cycle(c);
      if (c == abort_c) begin
        r_exp = exp_bits(ncap_of(c), 0);
        t_exp = exp_bits(ncap_of(c), 1);
        pidx  = pair_of(c);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
          check($sformatf("abort+%0d busy", k), busy, 0);
          check($sformatf("abort+%0d ro_enable", k), ro_enable, 0);
          check($sformatf("abort+%0d cnt_en", k), cnt_en, 0);
          check($sformatf("abort+%0d cnt_clear", k), cnt_clear, 0);
          check($sformatf("abort+%0d resp_valid", k), resp_valid, 0);
          check($sformatf("abort+%0d pair_sel", k), pair_sel, pidx);
          check($sformatf("abort+%0d response", k), response, r_exp);
          check($sformatf("abort+%0d tie_mask", k), tie_mask, t_exp);
          tick();
        end
        return;
      end
      if (c == rst_c) begin
        #3 rst = 1'b1;
        #1 check_reset_zero("async_rst");
        #2 rst = 1'b0;
        tick();
        check_reset_zero("post_rst");
        return;
      end
      start = (c == p1) || (c == p2);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; count_a = '0; count_b = '0;
    for (int j = 0; j < NB; j++) begin ca[j] = '0; cb[j] = '0; end
    #1 check_reset_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_reset_zero("idle");

    // abort and start together in IDLE must not start a run
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle busy", busy, 0);
    check("abort_start_idle cnt_clear", cnt_clear, 0);

    ca = '{8'd200, 8'd50, 8'd200, 8'd50};
    cb = '{8'd100, 8'd60, 8'd100, 8'd60};
    run(-1, -1, -1, -1);
    check("full response", response, 4'b0101);
    check("full tie_mask", tie_mask, 4'b0000);

    ca = '{8'd10, 8'd77, 8'd10, 8'd10};
    cb = '{8'd5,  8'd77, 8'd5,  8'd5};
    run(-1, -1, -1, -1);
    check("tie response", response, 4'b1101);
    check("tie tie_mask", tie_mask, 4'b0010);

    randomize_counts();
    run(-1, -1, 5, LAST_C);

    for (int n = 0; n < 4; n++) begin
      randomize_counts();
      run(-1, -1, -1, -1);
    end

    randomize_counts();
    run(20, -1, -1, -1);
    randomize_counts();
    run(-1, -1, -1, -1);

    randomize_counts();
    run(-1, 30, -1, -1);
    randomize_counts();
    run(-1, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
